// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line, frame configuration and result strobes that
//               connect a UART receiver to its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stop_err;

  // User side: drives the line and configuration, consumes results.
  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stop_err
  );

  // Receiver side.
  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stop_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver. Start bit, DATA_WIDTH data bits
//               LSB first, optional parity bit, one stop bit. Each bit is a
//               majority vote of three mid-bit samples.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave rx_if
);

  localparam int                    BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [1:0]            samp_q, samp_d;     // captures at P/2-1 and P/2
  logic                  vbit_q, vbit_d;     // voted value of the current bit
  logic                  perr_q, perr_d;     // parity error seen in this frame
  logic                  armed_q, armed_d;   // line seen idle since reset
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic [PRESCALE_W-1:0] half_pt;
  logic                  at_lo, at_mid, at_hi, at_last;
  logic                  vote;

  // Sample points within a bit, derived from the prescale latched at start.
  assign half_pt = presc_q >> 1;
  assign at_lo   = (edge_q == half_pt - P_ONE);
  assign at_mid  = (edge_q == half_pt);
  assign at_hi   = (edge_q == half_pt + P_ONE);
  assign at_last = (edge_q == presc_q - P_ONE);

  // Third sample is the live line value; majority is resolved at P/2+1.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_if.RX_IN) | (samp_q[1] & rx_if.RX_IN);

  assign rx_if.P_DATA     = pdata_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.par_err    = pe_q;
  assign rx_if.stop_err   = se_q;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Counters, sampling, shift register and registered result strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q    <= '0;
      presc_q   <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      pdata_q   <= '0;
      samp_q    <= '0;
      vbit_q    <= 1'b0;
      perr_q    <= 1'b0;
      armed_q   <= 1'b0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      edge_q    <= edge_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      samp_q    <= samp_d;
      vbit_q    <= vbit_d;
      perr_q    <= perr_d;
      armed_q   <= armed_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    samp_d    = samp_q;
    vbit_d    = vbit_q;
    perr_d    = perr_q;
    armed_d   = armed_q | rx_if.RX_IN;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    // Bit timing is common to every in-frame state.
    if (state_q != IDLE) begin
      edge_d = at_last ? '0 : edge_q + P_ONE;
      if (at_lo)  samp_d[0] = rx_if.RX_IN;
      if (at_mid) samp_d[1] = rx_if.RX_IN;
      if (at_hi)  vbit_d    = vote;
    end

    unique case (state_q)
      IDLE: begin
        // This cycle is edge 0 of the start bit, so the next one is edge 1.
        if (!rx_if.RX_IN && armed_q) begin
          state_d   = START;
          edge_d    = P_ONE;
          presc_d   = rx_if.Prescale;
          par_en_d  = rx_if.PAR_EN;
          par_typ_d = rx_if.PAR_TYP;
          bit_d     = '0;
          perr_d    = 1'b0;
        end
      end

      START: begin
        if (at_hi && vote) begin
          state_d = IDLE;     // glitch, not a real start bit
          edge_d  = '0;
        end else if (at_last) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (at_hi) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = vote;
        end
        if (at_last) begin
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      PARITY: begin
        if (at_hi) perr_d = (vote != ((^shift_q) ^ par_typ_q));
        if (at_last) begin
          pe_d    = perr_q;
          state_d = STOP;
        end
      end

      STOP: begin
        if (at_last) begin
          state_d = IDLE;
          if (!vbit_q) begin
            se_d = 1'b1;
          end else if (!perr_q) begin
            dv_d    = 1'b1;
            pdata_d = shift_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
        edge_d  = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
